// File: rtl/fix_div_hs.sv
// fix_div_hs -- sequential sign-magnitude fixed-point divider with
// valid/ready handshakes on both sides.
//
// Parameters
//   N : total word width (bit N-1 sign, bits N-2:0 magnitude), N >= 4
//   Q : fraction bits within the magnitude, 1 <= Q <= N-2
//
// Ports
//   clk, rst     : clock (rising edge), synchronous active-high reset
//   in_valid     : operand pair valid
//   in_ready     : divider idle and accepting operands (state == IDLE)
//   in_dividend  : sign-magnitude dividend, Q fraction bits
//   in_divisor   : sign-magnitude divisor, Q fraction bits
//   out_valid    : result valid (state == DONE)
//   out_ready    : consumer accepts result
//   out_quot     : sign-magnitude quotient, Q fraction bits
//   out_ovf      : quotient exceeded the magnitude range and was saturated
//   out_dbz      : divisor magnitude was zero
//
// Optional feature macro: FIX_DIV_ROUND_EN
//   defined   : one extra iteration produces a guard bit; the magnitude is
//               rounded half up, latency K+1 (K = N-1+Q)
//   undefined : truncation toward zero, latency K
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both 1. valid/ready are pure decodes of the registered state, so there
// is no combinational path from in_valid or out_ready to either of them.
// Operands offered while busy are ignored; results are held stable in DONE
// until out_ready is seen.

module fix_div_hs #(
  parameter int N = 32,
  parameter int Q = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_dividend,
  input  logic [N-1:0] in_divisor,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_quot,
  output logic         out_ovf,
  output logic         out_dbz
);

  localparam int K = N - 1 + Q;
`ifdef FIX_DIV_ROUND_EN
  localparam int ITER = K + 1;
`else
  localparam int ITER = K;
`endif
  localparam int CW = $clog2(ITER);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  // num_q starts as the numerator and shifts left each step; quotient bits
  // enter at the bottom, so after ITER steps it holds the full quotient.
  logic [ITER-1:0] num_q, num_d;
  logic [N-1:0]    rem_q, rem_d;
  logic [N-2:0]    b_q, b_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            sign_q, sign_d;
  logic [N-1:0]    quot_q, quot_d;
  logic            ovf_q, ovf_d;
  logic            dbz_q, dbz_d;

  // One restoring-division step.
  logic [N:0]      r_wide;
  logic            r_ge;
  logic [ITER-1:0] quo_full;

  always_comb begin
    r_wide   = {rem_q, num_q[ITER-1]};
    r_ge     = (r_wide >= {2'b00, b_q});
    quo_full = {num_q[ITER-2:0], r_ge};
  end

  // Final magnitude / overflow from the complete quotient bit string.
  logic [N-2:0] fin_mag;
  logic         fin_ovf;

`ifdef FIX_DIV_ROUND_EN
  logic [N-1:0] rsum;
  always_comb begin
    // Truncated magnitude is quo_full[N-1:1]; quo_full[0] is the guard bit.
    rsum    = {1'b0, quo_full[N-1:1]} + {{(N-1){1'b0}}, quo_full[0]};
    fin_ovf = (|quo_full[ITER-1:N]) | rsum[N-1];
    fin_mag = fin_ovf ? {(N-1){1'b1}} : rsum[N-2:0];
  end
`else
  always_comb begin
    // The top Q quotient bits lie above the representable magnitude.
    fin_ovf = |quo_full[ITER-1:N-1];
    fin_mag = fin_ovf ? {(N-1){1'b1}} : quo_full[N-2:0];
  end
`endif

  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    rem_d   = rem_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    quot_d  = quot_q;
    ovf_d   = ovf_q;
    dbz_d   = dbz_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          sign_d = in_dividend[N-1] ^ in_divisor[N-1];
          b_d    = in_divisor[N-2:0];
          num_d  = {in_dividend[N-2:0], {(ITER-(N-1)){1'b0}}};
          rem_d  = '0;
          cnt_d  = CW'(ITER - 1);
          if (in_divisor[N-2:0] == '0) begin
            // All-ones magnitude is never zero, so the sign is kept.
            quot_d  = {in_dividend[N-1] ^ in_divisor[N-1], {(N-1){1'b1}}};
            ovf_d   = 1'b0;
            dbz_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        num_d = quo_full;
        // R < B < 2^(N-1), so the shifted remainder always fits in N bits.
        rem_d = r_ge ? N'(r_wide - {2'b00, b_q}) : r_wide[N-1:0];
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          quot_d  = {sign_q & (|fin_mag), fin_mag};
          ovf_d   = fin_ovf;
          dbz_d   = 1'b0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      num_q   <= '0;
      rem_q   <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      quot_q  <= '0;
      ovf_q   <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      rem_q   <= rem_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      quot_q  <= quot_d;
      ovf_q   <= ovf_d;
      dbz_q   <= dbz_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign out_quot  = quot_q;
  assign out_ovf   = ovf_q;
  assign out_dbz   = dbz_q;

endmodule

// File: tb/tb_fix_div_hs.sv
// tb_fix_div_hs -- directed and randomized checks of fix_div_hs (N=16, Q=8)
// against an arithmetic reference model of fixed-point division.

module tb_fix_div_hs;

  localparam int N = 16;
  localparam int Q = 8;
  localparam int K = N - 1 + Q;
`ifdef FIX_DIV_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif
  localparam int LAT = ROUND ? K + 1 : K;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_dividend;
  logic [N-1:0] in_divisor;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_quot;
  logic         out_ovf;
  logic         out_dbz;

  int tests = 0;
  int fails = 0;

  fix_div_hs #(.N(N), .Q(Q)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_dividend (in_dividend),
    .in_divisor  (in_divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_quot    (out_quot),
    .out_ovf     (out_ovf),
    .out_dbz     (out_dbz)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Quotient magnitude = floor(A * 2^Q / B), or rounded half up when
  // rounding is enabled; anything above the largest magnitude saturates.
  function automatic void model(input logic [N-1:0] dd, input logic [N-1:0] dv,
                                output logic [N-1:0] q, output logic ovf,
                                output logic dbz);
    longint a, b, mag, t, maxm;
    logic   sign;
    a    = longint'(dd[N-2:0]);
    b    = longint'(dv[N-2:0]);
    maxm = (longint'(1) << (N - 1)) - 1;
    sign = dd[N-1] ^ dv[N-1];
    if (b == 0) begin
      q   = {sign, {(N-1){1'b1}}};
      ovf = 1'b0;
      dbz = 1'b1;
      return;
    end
    dbz = 1'b0;
    if (ROUND) begin
      t   = (a << (Q + 1)) / b;
      mag = (t >> 1) + (t & 1);
    end else begin
      mag = (a << Q) / b;
    end
    ovf = (mag > maxm);
    if (ovf) mag = maxm;
    q = {(mag != 0) ? sign : 1'b0, mag[N-2:0]};
  endfunction

  // ---------------- scoreboard check ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Issue one operation, measure latency, hold the result for 'hold'
  // cycles (optionally offering new operands meanwhile), then hand it off.
  task automatic do_op(input logic [N-1:0] dd, input logic [N-1:0] dv,
                       input int hold, input bit inject);
    logic [N-1:0] eq;
    logic         eovf, edbz;
    int           lat, elat;
    model(dd, dv, eq, eovf, edbz);
    // A zero divisor goes straight to DONE on the accept edge itself.
    elat = edbz ? 0 : LAT;
    @(negedge clk);
    check("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid    = 1'b1;
    in_dividend = dd;
    in_divisor  = dv;
    @(posedge clk);
    #1;
    in_valid    = 1'b0;
    in_dividend = N'($urandom);
    in_divisor  = N'($urandom);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check($sformatf("latency %h/%h", dd, dv), 32'(lat), 32'(elat));
    check($sformatf("quot %h/%h", dd, dv), 32'(out_quot), 32'(eq));
    check($sformatf("ovf %h/%h", dd, dv), 32'(out_ovf), 32'(eovf));
    check($sformatf("dbz %h/%h", dd, dv), 32'(out_dbz), 32'(edbz));
    check("in_ready_busy", 32'(in_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (inject && i == 1) begin
        in_valid    = 1'b1;
        in_dividend = N'($urandom);
        in_divisor  = N'($urandom);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      check("hold_quot", 32'(out_quot), 32'(eq));
      check("hold_flags", {30'd0, out_ovf, out_dbz}, {30'd0, eovf, edbz});
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("handoff_valid", 32'(out_valid), 32'd0);
    check("handoff_in_ready", 32'(in_ready), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [N-1:0] dd, dv;
    int           seen;
    rst         = 1'b1;
    in_valid    = 1'b0;
    in_dividend = '0;
    in_divisor  = '0;
    out_ready   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_quot", 32'(out_quot), 32'd0);
    check("rst_flags", {30'd0, out_ovf, out_dbz}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases
    do_op(16'h0100, 16'h0200, 0, 1'b0);   // 1.0 / 2.0
    do_op(16'h0300, 16'h8180, 0, 1'b0);   // 3.0 / -1.5
    do_op(16'h8000, 16'h0200, 0, 1'b0);   // -0 / 2.0, sign cleared
    do_op(16'h6400, 16'h0080, 0, 1'b0);   // overflow
    do_op(16'h8100, 16'h0000, 0, 1'b0);   // divide by zero
    do_op(16'h0200, 16'h0300, 0, 1'b0);   // 2/3 rounding
    do_op(16'h0100, 16'h0300, 0, 1'b0);   // 1/3
    do_op(16'h7FFF, 16'h0001, 1, 1'b0);   // largest / smallest
    do_op(16'h0001, 16'h7FFF, 2, 1'b0);   // smallest / largest
    do_op(16'h0300, 16'h8180, 5, 1'b1);   // backpressure with ignored operands

    // Explicit rounding reference values
    @(negedge clk);
    in_valid = 1'b1; in_dividend = 16'h0200; in_divisor = 16'h0300;
    @(posedge clk); #1; in_valid = 1'b0;
    seen = 0;
    while (!out_valid && seen < 200) begin @(posedge clk); #1; seen++; end
    check("round_2_3", 32'(out_quot), ROUND ? 32'h00AB : 32'h00AA);
    @(negedge clk); out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;

    // Reset mid-CALC discards the operation
    @(negedge clk);
    in_valid = 1'b1; in_dividend = 16'h0100; in_divisor = 16'h0200;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_quot", 32'(out_quot), 32'd0);
    seen = 0;
    repeat (LAT + 5) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1;
    end
    check("abort_no_valid", 32'(seen), 32'd0);

    // Randomized cases
    for (int n = 0; n < 40; n++) begin
      dd = N'($urandom_range(0, 65535));
      case ($urandom_range(0, 9))
        0:       dv = {1'($urandom_range(0, 1)), 15'd0};
        1, 2, 3: dv = {1'($urandom_range(0, 1)), 15'($urandom_range(1, 255))};
        default: dv = N'($urandom_range(0, 65535));
      endcase
      do_op(dd, dv, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
